// File: rtl/uart_pkg.sv
// Shared constants, state encoding and baud helper for the UART NIC controller
// and its receive core.
package uart_pkg;

    localparam int WORD_SIZE     = 8;
    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_nic_controller_if.sv
// Host-side bus of the UART NIC: TX write strobe, RX read strobe and RX head.
// frame_err/frame_err_cnt exist only when UART_FRAME_ERR_EN is defined.
interface uart_nic_controller_if;
    import uart_pkg::*;

    logic [WORD_SIZE-1:0] data_in;
    logic                 write_nic;
    logic                 read_nic;
    logic [WORD_SIZE-1:0] data_out;
    logic                 read_nic_i;
`ifdef UART_FRAME_ERR_EN
    logic                 frame_err;
    logic [7:0]           frame_err_cnt;

    modport master (
        output data_in, write_nic, read_nic,
        input  data_out, read_nic_i, frame_err, frame_err_cnt
    );
    modport slave (
        input  data_in, write_nic, read_nic,
        output data_out, read_nic_i, frame_err, frame_err_cnt
    );
`else
    modport master (
        output data_in, write_nic, read_nic,
        input  data_out, read_nic_i
    );
    modport slave (
        input  data_in, write_nic, read_nic,
        output data_out, read_nic_i
    );
`endif

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchroniser plus mid-bit sampling FSM, emitting a byte
// with a one-cycle valid pulse. UART_FRAME_ERR_EN adds a stop-bit failure pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] rx_byte,
    output logic                 rx_valid
`ifdef UART_FRAME_ERR_EN
    ,
    output logic                 rx_frame_err
`endif
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);

    logic [1:0]           sync_r;
    logic                 rx_sync_s;
    uart_state_e          state_r, state_next_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;
    logic [BIT_W-1:0]     bit_r, bit_next_s;
    logic [WORD_SIZE-1:0] shift_r, shift_next_s;
    logic [WORD_SIZE-1:0] byte_r;
    logic                 valid_r, valid_d_s;
    logic                 stop_sample_s;
`ifdef UART_FRAME_ERR_EN
    logic                 err_r, err_d_s;
`endif

    assign rx_sync_s = sync_r[1];

    // State register, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r  <= 2'b11;
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {WORD_SIZE{1'b0}};
            byte_r  <= {WORD_SIZE{1'b0}};
            valid_r <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            err_r   <= 1'b0;
`endif
        end else begin
            sync_r  <= {sync_r[0], rx};
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
            valid_r <= valid_d_s;
            if (valid_d_s) begin
                byte_r <= shift_r;
            end
`ifdef UART_FRAME_ERR_EN
            err_r   <= err_d_s;
`endif
        end
    end

    // Next-state logic: START re-checks at half a bit, later samples sit mid-bit
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        case (state_r)
            IDLE: begin
                if (!rx_sync_s) begin
                    state_next_s = START;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_END) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    bit_next_s   = {BIT_W{1'b0}};
                    state_next_s = rx_sync_s ? IDLE : DATA;
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (cnt_r == BIT_END) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    shift_next_s = {rx_sync_s, shift_r[WORD_SIZE-1:1]};
                    if (bit_r == LAST_BIT) begin
                        state_next_s = STOP;
                    end else begin
                        bit_next_s = bit_r + 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (cnt_r == BIT_END) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = rx_sync_s ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode at the stop-bit sample point
    always_comb begin
        stop_sample_s = (state_r == STOP) && (cnt_r == BIT_END);
        valid_d_s     = stop_sample_s && rx_sync_s;
`ifdef UART_FRAME_ERR_EN
        err_d_s       = stop_sample_s && !rx_sync_s;
`endif
    end

    assign rx_byte  = byte_r;
    assign rx_valid = valid_r;
`ifdef UART_FRAME_ERR_EN
    assign rx_frame_err = err_r;
`endif

endmodule

// File: rtl/uart_nic_controller.sv
// Full-duplex 8N1 UART NIC: host TX FIFO feeding a serialiser, uart_rx_core feeding an
// RX FIFO with first-word-fall-through head. UART_FRAME_ERR_EN adds framing-error outputs.
module uart_nic_controller
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_nic_controller_if.slave host,
    input  logic                 rx,
    output logic                 tx
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WORD_SIZE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_SIZE - 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] tx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wr_ptr_r, tx_rd_ptr_r;
    logic [FILL_W-1:0]    tx_fill_r;
    logic                 tx_push_s, tx_pop_s, tx_fifo_ne_s;
    logic [WORD_SIZE-1:0] tx_head_s;

    uart_state_e          tx_state_r, tx_state_next_s;
    logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_next_s;
    logic [BIT_W-1:0]     tx_bit_r, tx_bit_next_s;
    logic [WORD_SIZE-1:0] tx_shift_r, tx_shift_next_s;
    logic                 tx_r, tx_d_s;

    logic [WORD_SIZE-1:0] rx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     rx_wr_ptr_r, rx_rd_ptr_r, rx_wr_ptr_next_s, rx_rd_ptr_next_s;
    logic [FILL_W-1:0]    rx_fill_r, rx_fill_next_s;
    logic                 rx_push_s, rx_pop_s;
    logic [WORD_SIZE-1:0] rx_head_next_s, rx_data_out_r;
    logic                 rx_irq_r;
    logic [WORD_SIZE-1:0] rx_byte_s;
    logic                 rx_valid_s;
`ifdef UART_FRAME_ERR_EN
    logic                 rx_frame_err_s;
    logic                 frame_err_r;
    logic [7:0]           frame_err_cnt_r;
`endif

    assign tx_fifo_ne_s = (tx_fill_r != {FILL_W{1'b0}});
    assign tx_push_s    = host.write_nic && (tx_fill_r != FULL_FILL);
    assign tx_head_s    = tx_mem_r[tx_rd_ptr_r];

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= host.data_in;
        end
    end

    // TX FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wr_ptr_r <= {PTR_W{1'b0}};
            tx_rd_ptr_r <= {PTR_W{1'b0}};
            tx_fill_r   <= {FILL_W{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_fill_r <= tx_fill_r + 1'b1;
                2'b01:   tx_fill_r <= tx_fill_r - 1'b1;
                default: tx_fill_r <= tx_fill_r;
            endcase
        end
    end

    // TX FSM state register with the registered serial output
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_r <= IDLE;
            tx_cnt_r   <= {CNT_W{1'b0}};
            tx_bit_r   <= {BIT_W{1'b0}};
            tx_shift_r <= {WORD_SIZE{1'b0}};
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_cnt_r   <= tx_cnt_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_r       <= tx_d_s;
        end
    end

    // TX next-state: STOP chains straight into START when another byte waits
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_cnt_next_s   = tx_cnt_r;
        tx_bit_next_s   = tx_bit_r;
        tx_shift_next_s = tx_shift_r;
        case (tx_state_r)
            IDLE: begin
                if (tx_fifo_ne_s) begin
                    tx_state_next_s = START;
                    tx_cnt_next_s   = {CNT_W{1'b0}};
                    tx_shift_next_s = tx_head_s;
                end else begin
                    tx_state_next_s = IDLE;
                end
            end
            START: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_state_next_s = DATA;
                    tx_cnt_next_s   = {CNT_W{1'b0}};
                    tx_bit_next_s   = {BIT_W{1'b0}};
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_next_s   = {CNT_W{1'b0}};
                    tx_shift_next_s = {1'b0, tx_shift_r[WORD_SIZE-1:1]};
                    if (tx_bit_r == LAST_BIT) begin
                        tx_state_next_s = STOP;
                    end else begin
                        tx_bit_next_s = tx_bit_r + 1'b1;
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_next_s = {CNT_W{1'b0}};
                    if (tx_fifo_ne_s) begin
                        tx_state_next_s = START;
                        tx_shift_next_s = tx_head_s;
                    end else begin
                        tx_state_next_s = IDLE;
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_next_s = IDLE;
                tx_cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // TX outputs: FIFO pop on frame launch, line level for the upcoming cycle
    always_comb begin
        case (tx_state_r)
            IDLE:    tx_pop_s = tx_fifo_ne_s;
            STOP:    tx_pop_s = (tx_cnt_r == BIT_END) && tx_fifo_ne_s;
            default: tx_pop_s = 1'b0;
        endcase
        case (tx_state_next_s)
            START:   tx_d_s = 1'b0;
            DATA:    tx_d_s = tx_shift_next_s[0];
            default: tx_d_s = 1'b1;
        endcase
    end

    assign tx = tx_r;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_byte      (rx_byte_s),
        .rx_valid     (rx_valid_s)
`ifdef UART_FRAME_ERR_EN
        ,
        .rx_frame_err (rx_frame_err_s)
`endif
    );

    assign rx_pop_s  = host.read_nic && (rx_fill_r != {FILL_W{1'b0}});
    assign rx_push_s = rx_valid_s && ((rx_fill_r != FULL_FILL) || rx_pop_s);

    // RX FIFO next pointers and the head value visible after this edge
    always_comb begin
        if (rx_push_s) begin
            rx_wr_ptr_next_s = rx_wr_ptr_r + 1'b1;
        end else begin
            rx_wr_ptr_next_s = rx_wr_ptr_r;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_next_s = rx_rd_ptr_r + 1'b1;
        end else begin
            rx_rd_ptr_next_s = rx_rd_ptr_r;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_fill_next_s = rx_fill_r + 1'b1;
            2'b01:   rx_fill_next_s = rx_fill_r - 1'b1;
            default: rx_fill_next_s = rx_fill_r;
        endcase
        if (rx_fill_next_s == {FILL_W{1'b0}}) begin
            rx_head_next_s = {WORD_SIZE{1'b0}};
        end else if (rx_push_s && (rx_rd_ptr_next_s == rx_wr_ptr_r)) begin
            rx_head_next_s = rx_byte_s;
        end else begin
            rx_head_next_s = rx_mem_r[rx_rd_ptr_next_s];
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= rx_byte_s;
        end
    end

    // RX FIFO state plus registered head and interrupt level
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wr_ptr_r   <= {PTR_W{1'b0}};
            rx_rd_ptr_r   <= {PTR_W{1'b0}};
            rx_fill_r     <= {FILL_W{1'b0}};
            rx_data_out_r <= {WORD_SIZE{1'b0}};
            rx_irq_r      <= 1'b0;
        end else begin
            rx_wr_ptr_r   <= rx_wr_ptr_next_s;
            rx_rd_ptr_r   <= rx_rd_ptr_next_s;
            rx_fill_r     <= rx_fill_next_s;
            rx_data_out_r <= rx_head_next_s;
            rx_irq_r      <= (rx_fill_next_s != {FILL_W{1'b0}});
        end
    end

    assign host.data_out   = rx_data_out_r;
    assign host.read_nic_i = rx_irq_r;

`ifdef UART_FRAME_ERR_EN
    // Framing-error pulse and saturating tally
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err_r     <= 1'b0;
            frame_err_cnt_r <= 8'd0;
        end else begin
            frame_err_r <= rx_frame_err_s;
            if (rx_frame_err_s && (frame_err_cnt_r != 8'hFF)) begin
                frame_err_cnt_r <= frame_err_cnt_r + 8'd1;
            end
        end
    end

    assign host.frame_err     = frame_err_r;
    assign host.frame_err_cnt = frame_err_cnt_r;
`endif

endmodule

// File: tb/tb_uart_nic_controller.sv
// Directed bench for uart_nic_controller: instance A's tx drives instance B's rx,
// and the bench drives A's rx directly.
module tb_uart_nic_controller;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } tx_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_a = 1'b1;
    logic tx_a;
    logic tx_b;

    uart_nic_controller_if if_a ();
    uart_nic_controller_if if_b ();

    uart_nic_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .host(if_a), .rx(rx_a), .tx(tx_a)
    );
    uart_nic_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .host(if_b), .rx(tx_a), .tx(tx_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ri_high_a = 0;
`ifdef UART_FRAME_ERR_EN
    int err_pulse_a = 0;
`endif

    // Running tallies of interrupt-high and framing-error cycles on instance A
    always @(negedge clk) begin
        if (if_a.read_nic_i) ri_high_a <= ri_high_a + 1;
`ifdef UART_FRAME_ERR_EN
        if (if_a.frame_err) err_pulse_a <= err_pulse_a + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_a(input logic [7:0] d);
        if_a.data_in   = d;
        if_a.write_nic = 1'b1;
        @(negedge clk);
        if_a.write_nic = 1'b0;
    endtask

    task automatic pop_b();
        if_b.read_nic = 1'b1;
        @(negedge clk);
        if_b.read_nic = 1'b0;
    endtask

    task automatic pop_a();
        if_a.read_nic = 1'b1;
        @(negedge clk);
        if_a.read_nic = 1'b0;
    endtask

    // Waits (bounded) for A's start bit, then samples each of the 10 bits mid-bit
    task automatic capture_a(output logic [9:0] frame);
        int w;
        w = 0;
        while (tx_a !== 1'b0 && w < 4 * CPB) begin
            @(negedge clk);
            w++;
        end
        tick(CPB / 2 - 1);
        for (int i = 0; i < 10; i++) begin
            frame[i] = tx_a;
            if (i < 9) tick(CPB);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop, input int gap);
        rx_a = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            tick(CPB);
        end
        rx_a = stop;
        tick(CPB);
        rx_a = 1'b1;
        tick(gap);
    endtask

    function automatic logic [7:0] vg_byte(input int j);
        int v;
        v = j * j + 3 * j + 5 + (j + 1) * (j + 1) * (j + 1);
        return 8'(v % 256);
    endfunction

    tx_vec_t    tx_vecs [5];
    logic [9:0] frame;
    logic [7:0] got_q [$];
    int zeros;
    int k;
    int budget;
    int ri0;
`ifdef UART_FRAME_ERR_EN
    int ef0;
`endif

    initial begin
        tx_vecs[0] = '{data: 8'h55, frame: 10'b1010101010};
        tx_vecs[1] = '{data: 8'hA3, frame: 10'b1101000110};
        tx_vecs[2] = '{data: 8'h00, frame: 10'b1000000000};
        tx_vecs[3] = '{data: 8'hFF, frame: 10'b1111111110};
        tx_vecs[4] = '{data: 8'h80, frame: 10'b1100000000};

        if_a.data_in = 8'h00; if_a.write_nic = 1'b0; if_a.read_nic = 1'b0;
        if_b.data_in = 8'h00; if_b.write_nic = 1'b0; if_b.read_nic = 1'b0;

        tick(3);
        check("reset_tx", {31'd0, tx_a}, 32'd1);
        check("reset_irq", {31'd0, if_a.read_nic_i}, 32'd0);
        check("reset_data_out", {24'd0, if_a.data_out}, 32'd0);
`ifdef UART_FRAME_ERR_EN
        check("reset_frame_err_cnt", {24'd0, if_a.frame_err_cnt}, 32'd0);
`endif
        rst = 1'b1;
        tick(2);

        // Table: serial frame on A's tx and the byte landing in B's RX FIFO
        for (int v = 0; v < 5; v++) begin
            write_a(tx_vecs[v].data);
            capture_a(frame);
            check("tx_frame", {22'd0, frame}, {22'd0, tx_vecs[v].frame});
            zeros = 0;
            for (int i = 0; i < CPB; i++) begin
                if (tx_a !== 1'b1) zeros++;
                tick(1);
            end
            check("tx_idle_after", zeros, 0);
            check("link_irq", {31'd0, if_b.read_nic_i}, 32'd1);
            check("link_data", {24'd0, if_b.data_out}, {24'd0, tx_vecs[v].data});
            pop_b();
            check("link_irq_clear", {31'd0, if_b.read_nic_i}, 32'd0);
            tick(CPB);
        end

        // Back-to-back writes three cycles apart: gapless frames, both queued in order
        if_a.data_in = 8'h55; if_a.write_nic = 1'b1;
        tick(1);
        if_a.write_nic = 1'b0;
        tick(1);
        check("b2b_start_latency", {31'd0, tx_a}, 32'd0);
        tick(1);
        if_a.data_in = 8'hAA; if_a.write_nic = 1'b1;
        tick(1);
        if_a.write_nic = 1'b0;
        tick(10 * CPB - 3);
        check("b2b_stop_bit", {31'd0, tx_a}, 32'd1);
        tick(1);
        check("b2b_no_idle_gap", {31'd0, tx_a}, 32'd0);
        tick(12 * CPB);
        check("b2b_irq", {31'd0, if_b.read_nic_i}, 32'd1);
        check("b2b_first", {24'd0, if_b.data_out}, 32'h55);
        pop_b();
        check("b2b_second", {24'd0, if_b.data_out}, 32'hAA);
        pop_b();
        check("b2b_irq_clear", {31'd0, if_b.read_nic_i}, 32'd0);
        check("b2b_empty_out", {24'd0, if_b.data_out}, 32'd0);

        // Variable-gap RX on A with concurrent draining
        k = 0;
        budget = 0;
        fork
            begin
                for (int j = 0; j < 14; j++) send_rx(vg_byte(j), 1'b1, j * CPB / 4);
            end
            begin
                while (k < 14 && budget < 4000) begin
                    if (if_a.read_nic_i) begin
                        check("vgap_byte", {24'd0, if_a.data_out}, {24'd0, vg_byte(k)});
                        k++;
                        pop_a();
                    end else begin
                        @(negedge clk);
                    end
                    budget++;
                end
            end
        join
        check("vgap_count", k, 14);

        // Framing error: stop bit low, nothing queued
        tick(2);
        ri0 = ri_high_a;
`ifdef UART_FRAME_ERR_EN
        ef0 = err_pulse_a;
`endif
        send_rx(8'h3C, 1'b0, 3 * CPB);
        check("ferr_irq_quiet", ri_high_a - ri0, 0);
`ifdef UART_FRAME_ERR_EN
        check("ferr_pulses", err_pulse_a - ef0, 1);
        check("ferr_count", {24'd0, if_a.frame_err_cnt}, 32'd1);
`endif

        // Glitch shorter than half a bit, then a clean frame
        ri0 = ri_high_a;
        rx_a = 1'b0;
        tick(CPB / 4);
        rx_a = 1'b1;
        tick(3 * CPB);
        check("glitch_irq_quiet", ri_high_a - ri0, 0);
        send_rx(8'h5A, 1'b1, CPB);
        check("glitch_recover_irq", {31'd0, if_a.read_nic_i}, 32'd1);
        check("glitch_recover_data", {24'd0, if_a.data_out}, 32'h5A);
        pop_a();
        check("glitch_recover_clear", {31'd0, if_a.read_nic_i}, 32'd0);
`ifdef UART_FRAME_ERR_EN
        check("glitch_no_ferr", {24'd0, if_a.frame_err_cnt}, 32'd1);
`endif

        // Overflow: six pushes on consecutive cycles, one in flight plus four queued
        for (int i = 0; i < 6; i++) begin
            if_a.data_in   = 8'h11 + 8'(i);
            if_a.write_nic = 1'b1;
            tick(1);
        end
        if_a.write_nic = 1'b0;
        for (int c = 0; c < 70 * CPB; c++) begin
            if (if_b.read_nic_i) begin
                got_q.push_back(if_b.data_out);
                pop_b();
            end else begin
                tick(1);
            end
        end
        check("ovf_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check("ovf_byte", {24'd0, got_q[i]}, 32'h11 + i);
        end

        // Reset mid-frame aborts TX and flushes both FIFOs
        send_rx(8'h77, 1'b1, CPB);
        check("rst_pre_irq", {31'd0, if_a.read_nic_i}, 32'd1);
        write_a(8'h00);
        write_a(8'h0F);
        tick(3 * CPB);
        check("rst_pre_tx_low", {31'd0, tx_a}, 32'd0);
        rst = 1'b0;
        tick(1);
        check("rst_tx_high", {31'd0, tx_a}, 32'd1);
        check("rst_irq_low", {31'd0, if_a.read_nic_i}, 32'd0);
        check("rst_data_out", {24'd0, if_a.data_out}, 32'd0);
        rst = 1'b1;
        zeros = 0;
        for (int i = 0; i < 15 * CPB; i++) begin
            if (tx_a !== 1'b1) zeros++;
            tick(1);
        end
        check("rst_tx_fifo_flushed", zeros, 0);
        check("rst_rx_fifo_flushed", {31'd0, if_a.read_nic_i}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_nic_controller.md
Name: uart_nic_controller

Overview:
- Full-duplex 8N1 UART "NIC" for the OS side.
- Bytes written by the host are queued in a TX FIFO and serialised on tx.
- Frames received on rx are validated and queued in an RX FIFO, which the host drains via a read strobe.
- Sits between the host bus and the serial pins; two instances cross-connected (tx→rx) form the system-level link test.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (5208), clock cycles per bit period.
- WORD_SIZE, 8, data bits per frame.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- data_in  in  WORD_SIZE  byte to transmit.
- write_nic  in  1  one-cycle strobe: push data_in into the TX FIFO.
- read_nic  in  1  one-cycle strobe: pop the head of the RX FIFO.
- rx  in  1  serial input, idle high, asynchronous.
- data_out  out  WORD_SIZE  head of the RX FIFO (first-word-fall-through); 0 when empty.
- read_nic_i  out  1  receive interrupt: high while the RX FIFO is non-empty.
- tx  out  1  serial output, idle high.

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-low.
- Reset values: tx=1; read_nic_i=0; data_out=0; both FIFOs empty; TX and RX FSMs in IDLE.
- Reset asserted mid-frame aborts it: tx returns to 1 on the next edge and any partial RX byte is discarded.
- Frame format: 1 start bit (0), WORD_SIZE data bits LSB first, 1 stop bit (1), no parity.
- TX FIFO push:
  - write_nic=1 and TX FIFO not full → data_in pushed.
  - write_nic while full → ignored (data lost).
- TX FSM IDLE→START→DATA→STOP→IDLE:
  - In IDLE with FIFO non-empty: pop, latch the byte, enter START on the next cycle.
  - Each state holds tx for exactly CLKS_PER_BIT cycles.
  - DATA shifts out bits 0..7.
  - On leaving STOP, if the FIFO is non-empty the next START begins immediately, with no extra idle.
- RX input conditioning: rx passes through a 2-FF synchroniser before use.
- RX FSM IDLE→START→DATA→STOP→IDLE:
  - IDLE: a synchronised 0 starts a frame.
  - START: re-sample at CLKS_PER_BIT/2. If high, it is a glitch; return to IDLE.
  - DATA: sample every CLKS_PER_BIT thereafter, at mid-bit, for 8 bits, assembled LSB first.
  - STOP: sample at mid-bit.
    - Sample = 1: push the byte into the RX FIFO (dropped if full) and return to IDLE immediately, so a back-to-back start bit is detected.
    - Sample = 0 (framing error): discard the byte; enter WAIT_IDLE until rx=1, then IDLE.
- RX FIFO read:
  - read_nic while non-empty pops; data_out shows the new head on the next cycle.
  - read_nic while empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO keeps the count constant.
- read_nic_i is a registered level, equal to RX FIFO non-empty. It rises 1 cycle after the push and falls 1 cycle after the pop that empties the FIFO.
- Baud counters are wide enough for CLKS_PER_BIT-1. TX and RX are fully independent.

Optional Feature:
- Macro: UART_FRAME_ERR_EN.
- When defined:
  - Extra output frame_err (1 bit, reset 0): a one-cycle pulse on each stop-bit failure.
  - Extra output frame_err_cnt (8 bits, reset 0): saturating count of framing errors.
- When undefined: neither port exists and framing errors are silently discarded.

Decomposition:
- Package uart_pkg: WORD_SIZE, default CLK_FREQ/BAUD_RATE, the CLKS_PER_BIT function, and the TX/RX state enums (IDLE, START, DATA, STOP, WAIT_IDLE).
- One natural sub-module, uart_rx_core: synchroniser plus RX FSM. Outputs a byte and a valid pulse to the controller.
- The TX FSM and both FIFOs stay in the top module.

Test Plan (benches may override CLKS_PER_BIT=16):
- Single byte: push 0x55 → tx, sampled at mid-bit, is 0,1,0,1,0,1,0,1,0,1 over 10×CLKS_PER_BIT cycles, then stays 1.
- Back-to-back: write 0x55 and 0xAA 3 cycles apart with two instances cross-linked; after both frames:
  - read_nic_i=1 and data_out=0x55.
  - read_nic → data_out=0xAA.
  - read_nic → read_nic_i=0.
- Variable-gap RX: drive 14 frames with bytes j²+3j+5+(j+1)³ mod 256 (0x06, 0x11, 0x2A, …) and idle gaps of 0.25·j bit periods → every byte is queued and the FIFO is drained in order (FIFO_DEPTH≥14 or drain concurrently).
- Framing error: drive a frame whose stop bit is 0, followed by idle → nothing queued, read_nic_i stays 0, frame_err pulses once (with UART_FRAME_ERR_EN).
- Glitch: pull rx low for CLKS_PER_BIT/4 cycles → no frame, FSM back in IDLE.
- Overflow/reset:
  - Push FIFO_DEPTH+2 bytes while idle → only the first FIFO_DEPTH are transmitted, plus the one already in flight.
  - Assert rst mid-frame → tx=1, FIFOs empty, read_nic_i=0.
